// File: rtl/fx3_bus_pkg.sv
// Shared definitions for the FX3 slave-FIFO bus controller: state codes,
// socket addresses, default timing and a counter-load helper.
package fx3_bus_pkg;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_IN_SETUP    = 3'd1;
  localparam logic [2:0] ST_IN_ACTIVE   = 3'd2;
  localparam logic [2:0] ST_IN_RELEASE  = 3'd3;
  localparam logic [2:0] ST_OUT_SETUP   = 3'd4;
  localparam logic [2:0] ST_OUT_ACTIVE  = 3'd5;
  localparam logic [2:0] ST_OUT_RELEASE = 3'd6;
  localparam logic [2:0] ST_TURNAROUND  = 3'd7;

  localparam logic [1:0] DEF_IN_SOCKET  = 2'b00;
  localparam logic [1:0] DEF_OUT_SOCKET = 2'b11;

  localparam int unsigned DEF_ADDR_SETUP_CYCLES = 2;
  localparam int unsigned DEF_TURNAROUND_CYCLES = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES    = 4096;

  typedef enum logic {
    SIDE_IN  = 1'b0,
    SIDE_OUT = 1'b1
  } side_e;

  // Down-counters terminate at zero, so an N-cycle wait loads N-1 (clamped to 4 bits).
  function automatic logic [3:0] cnt4_load(input int unsigned n);
    if (n == 0) return 4'd0;
    if (n > 16) return 4'd15;
    return 4'(n - 1);
  endfunction

endpackage

// File: rtl/fx3_rr_arbiter.sv
// Two-requester round-robin: on a tie the side not served last wins.
// last_served is updated by a strobe when a transfer ends.
module fx3_rr_arbiter
  import fx3_bus_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_req_in,
  input  logic  i_req_out,
  input  logic  i_update,
  input  side_e i_served,
  output logic  o_grant_in,
  output logic  o_grant_out
);

  side_e r_last_served;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_served <= SIDE_OUT;
    end else if (i_update) begin
      r_last_served <= i_served;
    end
  end

  assign o_grant_in  = i_req_in  && (!i_req_out || (r_last_served == SIDE_OUT));
  assign o_grant_out = i_req_out && (!i_req_in  || (r_last_served == SIDE_IN));

endmodule

// File: rtl/fx3_bus_controller.sv
// FX3 slave-FIFO bus sequencer: arbitrates inbound/outbound, sets up the socket
// address, holds the path enable until finished, then enforces turnaround.
//
// state          | meaning
// IDLE           | arbitrate requests, grant latches size and address
// IN_SETUP       | address stable, waiting before inbound enable
// IN_ACTIVE      | inbound enable high, timeout running
// IN_RELEASE     | enable low, waiting for inbound path to go quiet
// OUT_SETUP      | address stable, waiting before outbound enable
// OUT_ACTIVE     | outbound enable high, timeout running
// OUT_RELEASE    | enable low, waiting for outbound path to go quiet
// TURNAROUND     | idle gap before the next arbitration
module fx3_bus_controller
  import fx3_bus_pkg::*;
#(
  parameter logic [1:0]  IN_SOCKET         = DEF_IN_SOCKET,
  parameter logic [1:0]  OUT_SOCKET        = DEF_OUT_SOCKET,
  parameter int unsigned ADDR_SETUP_CYCLES = DEF_ADDR_SETUP_CYCLES,
  parameter int unsigned TURNAROUND_CYCLES = DEF_TURNAROUND_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_in_dma_ready,
  input  logic        i_out_dma_ready,
  input  logic        i_out_request,
  input  logic [23:0] i_cfg_packet_size,
  input  logic        i_in_path_busy,
  input  logic        i_in_path_finished,
  input  logic        i_out_path_busy,
  input  logic        i_out_path_finished,
  output logic [1:0]  o_address,
  output logic [23:0] o_packet_size,
  output logic        o_in_path_enable,
  output logic        o_read_flow_cntrl,
  output logic        o_out_path_enable,
  output logic        o_busy,
  output logic        o_timeout
);

  localparam int unsigned    TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]  TO_MAX     = '1;
  localparam logic [3:0]     SETUP_LOAD = cnt4_load(ADDR_SETUP_CYCLES);
  localparam logic [3:0]     TA_LOAD    = cnt4_load(TURNAROUND_CYCLES);
  localparam bit             TA_SKIP    = (TURNAROUND_CYCLES == 0);

  logic [2:0]    r_state;
  logic [3:0]    r_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [1:0]    r_address;
  logic [23:0]   r_packet_size;

  logic  w_size_nz;
  logic  w_in_req;
  logic  w_out_req;
  logic  w_grant_in;
  logic  w_grant_out;
  logic  w_in_active;
  logic  w_out_active;
  logic  w_to_hit;
  logic  w_in_done;
  logic  w_in_abort;
  logic  w_out_done;
  logic  w_out_abort;
  logic  w_in_end;
  logic  w_out_end;
  side_e w_served;

  assign w_size_nz = |i_cfg_packet_size;
  assign w_in_req  = i_in_dma_ready && w_size_nz;
  assign w_out_req = i_out_request && i_out_dma_ready && w_size_nz;

  assign w_in_active  = (r_state == ST_IN_ACTIVE);
  assign w_out_active = (r_state == ST_OUT_ACTIVE);
  assign w_to_hit     = (r_to_cnt == TO_LAST);

  // finished on the last allowed cycle is a normal completion, not an abort
  assign w_in_done   = w_in_active  &&  i_in_path_finished;
  assign w_in_abort  = w_in_active  && !i_in_path_finished  && w_to_hit;
  assign w_out_done  = w_out_active &&  i_out_path_finished;
  assign w_out_abort = w_out_active && !i_out_path_finished && w_to_hit;
  assign w_in_end    = w_in_done  || w_in_abort;
  assign w_out_end   = w_out_done || w_out_abort;
  assign w_served    = w_out_end ? SIDE_OUT : SIDE_IN;

  fx3_rr_arbiter u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_req_in    (w_in_req),
    .i_req_out   (w_out_req),
    .i_update    (w_in_end || w_out_end),
    .i_served    (w_served),
    .o_grant_in  (w_grant_in),
    .o_grant_out (w_grant_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_to_cnt      <= '0;
      r_address     <= IN_SOCKET;
      r_packet_size <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_in) begin
            r_state       <= ST_IN_SETUP;
            r_address     <= IN_SOCKET;
            r_packet_size <= i_cfg_packet_size;
            r_cnt         <= SETUP_LOAD;
          end else if (w_grant_out) begin
            r_state       <= ST_OUT_SETUP;
            r_address     <= OUT_SOCKET;
            r_packet_size <= i_cfg_packet_size;
            r_cnt         <= SETUP_LOAD;
          end
        end
        ST_IN_SETUP, ST_OUT_SETUP: begin
          if (r_cnt == 4'd0) begin
            r_state  <= (r_state == ST_IN_SETUP) ? ST_IN_ACTIVE : ST_OUT_ACTIVE;
            r_to_cnt <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_IN_ACTIVE: begin
          if (w_in_end) begin
            r_state <= ST_IN_RELEASE;
          end else if (r_to_cnt != TO_MAX) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ST_OUT_ACTIVE: begin
          if (w_out_end) begin
            r_state <= ST_OUT_RELEASE;
          end else if (r_to_cnt != TO_MAX) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ST_IN_RELEASE: begin
          if (!i_in_path_finished && !i_in_path_busy) begin
            r_state <= TA_SKIP ? ST_IDLE : ST_TURNAROUND;
            r_cnt   <= TA_LOAD;
          end
        end
        ST_OUT_RELEASE: begin
          if (!i_out_path_finished && !i_out_path_busy) begin
            r_state <= TA_SKIP ? ST_IDLE : ST_TURNAROUND;
            r_cnt   <= TA_LOAD;
          end
        end
        ST_TURNAROUND: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_address         = r_address;
  assign o_packet_size     = r_packet_size;
  assign o_in_path_enable  = w_in_active;
  assign o_out_path_enable = w_out_active;
  assign o_read_flow_cntrl = w_in_active && i_in_dma_ready;
  assign o_busy            = (r_state != ST_IDLE);
  assign o_timeout         = w_in_abort || w_out_abort;

endmodule

// File: doc/fx3_bus_controller.md
Name: fx3_bus_controller

Overview:
Sequencer and arbiter for the shared FX3 slave-FIFO bus. It chooses between the inbound path (FX3 to FPGA, fx3_bus_in_path) and the outbound path (FPGA to FX3). It drives the FX3 socket address and waits for address setup before enabling the selected path. It holds the path enable until the path reports finished, enforces bus turnaround and aborts hung transfers on timeout.

Parameters:
IN_SOCKET, 2'b00, FX3 socket address for the inbound thread
OUT_SOCKET, 2'b11, FX3 socket address for the outbound thread
ADDR_SETUP_CYCLES, 2, cycles o_address must be stable before a path enable rises (1..15)
TURNAROUND_CYCLES, 2, idle cycles after a path releases before the next grant (0..15)
TIMEOUT_CYCLES, 4096, max cycles in an ACTIVE state before abort (>=16)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_in_dma_ready  in  1  FX3 inbound thread flag: packet available
i_out_dma_ready  in  1  FX3 outbound thread flag: buffer space available
i_out_request  in  1  master has an outbound packet queued (level)
i_cfg_packet_size  in  24  packet size in words, latched at grant
i_in_path_busy  in  1  from in path
i_in_path_finished  in  1  from in path
i_out_path_busy  in  1  from out path
i_out_path_finished  in  1  from out path
o_address  out  2  FX3 socket address
o_packet_size  out  24  latched size to the granted path
o_in_path_enable  out  1  enable to in path
o_read_flow_cntrl  out  1  i_in_dma_ready gated by inbound grant, to in path
o_out_path_enable  out  1  enable to out path
o_busy  out  1  any state other than IDLE
o_timeout  out  1  one-cycle pulse on abort

Behaviour:
- Reset values: o_address=IN_SOCKET, o_packet_size=0, all enables/flags/o_busy/o_timeout=0, state=IDLE, last_served=OUT (inbound wins the first tie).
- States: IDLE, IN_SETUP, IN_ACTIVE, IN_RELEASE, OUT_SETUP, OUT_ACTIVE, OUT_RELEASE, TURNAROUND.
- IDLE arbitration:
  - in_req = i_in_dma_ready && size!=0.
  - out_req = i_out_request && i_out_dma_ready && size!=0.
  - If both are set, grant the side not in last_served (round-robin).
  - On grant: latch o_packet_size, set o_address, load the setup counter, go to xx_SETUP.
  - A zero size never grants.
- xx_SETUP: o_address is stable. After exactly ADDR_SETUP_CYCLES cycles in this state, go to xx_ACTIVE.
- xx_ACTIVE:
  - The granted enable is high, combinationally from state. In-path enable first rises ADDR_SETUP_CYCLES+1 cycles after the grant cycle.
  - o_read_flow_cntrl = i_in_dma_ready only in IN_ACTIVE, else 0.
  - The timeout counter resets on entry and increments each cycle.
  - On xx_path_finished, go to xx_RELEASE and update last_served.
  - If the counter reaches TIMEOUT_CYCLES-1 without finished: pulse o_timeout for 1 cycle, go to xx_RELEASE, update last_served.
- xx_RELEASE: enable low. Wait until the path's finished=0 and busy=0, then go to TURNAROUND. The path returns to IDLE when its enable drops.
- TURNAROUND: TURNAROUND_CYCLES cycles, then IDLE. With 0 it goes straight to IDLE on the next edge. No grant is evaluated in TURNAROUND.
- o_address holds its value from grant until the next grant and is never changed while an enable is high. Only one enable is ever high.
- Changes to i_cfg_packet_size after the grant are ignored until the next grant.
- Flag deassertion during ACTIVE (i_in_dma_ready low) only gates o_read_flow_cntrl. The grant is not dropped.
- rst mid-transfer: enables drop on the next edge and state=IDLE. Paths are reset by the same rst.
- Counters: setup/turnaround 4-bit, timeout $clog2(TIMEOUT_CYCLES) bits. All counters saturate and never wrap.

Decomposition:
- Shared package fx3_bus_pkg: state encodings, socket address constants, default timing constants.
- One natural sub-module, fx3_rr_arbiter: 2-requester round-robin with last_served register and grant-update strobe. All else is inline.

Test Plan:
- in_dma_ready=1, size=512, out idle -> o_address=00 at grant+1, o_in_path_enable rises at grant+3, held until in_path_finished, then low; IDLE after 1 release + 2 turnaround cycles.
- in and out both requesting continuously, size=16 -> grants alternate IN, OUT, IN, OUT; first grant is IN after reset.
- size=0 with in_dma_ready=1 -> stays IDLE, o_busy=0, no enable for 100 cycles.
- in path never signals finished, TIMEOUT_CYCLES=64 -> o_timeout one-cycle pulse at 64th ACTIVE cycle, enable drops next cycle, returns to IDLE.
- rst asserted mid IN_ACTIVE -> next cycle all outputs at reset values; new request afterwards grants normally.
- i_in_dma_ready toggles during IN_ACTIVE -> o_read_flow_cntrl follows it, enable and o_address unchanged.
